instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle control FSM for the 8-bit processor. Fetches the opcode for the
//  current program counter from eight_bit_rom and decodes it. Drives the one-cycle
//  strobes for the A/B/OUT eight_bit_registers, the ALU and the w_bus source mux.
//  Replaces the ad-hoc decode in the top level; every step is one one_shot_clock pulse.
// PARAMETERS
//  PC_W      8   program counter width
//  PROG_LEN  16  number of ROM words; last valid address = PROG_LEN-1
//  WRAP      0   1: pc wraps to 0 after last word; 0: enter HALT
// PORTS
//  one_shot_clock  in   1  step clock (debounced KEY[3] pulse)
//  reset           in   1  synchronous, active-high
//  run             in   1  enable stepping (SW[16])
//  instr           in   8  ROM word at address pc (combinational ROM)
//  pc              out  PC_W  program counter to ROM
//  ld_ir           out  1  instruction-register load strobe (FETCH)
//  ld_a            out  1  A register load from w_bus
//  ld_b            out  1  B register load from w_bus
//  ld_out          out  1  OUT register load from w_bus
//  alu_en          out  1  ALU latch strobe
//  alu_sel         out  4  ALU operation select
//  w_sel           out  3  w_bus source: 0 none(Z),1 ALU,2 SW[7:0],3 SW[15:8],4 A,5 B
//  state           out  3  FSM state code (to LEDs)
//  halted          out  1  high in HALT
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, ir_q=0, all strobes 0, alu_sel=0, w_sel=0, halted=0.
//  Reset takes priority over run and over any in-flight instruction.
//  States (code): IDLE(0) FETCH(1) DECODE(2) EXECUTE(3) HALT(4).
//  IDLE: run=1 -> FETCH; otherwise hold. pc is held.
//  FETCH: ld_ir=1; ir_q<=instr; -> DECODE.
//  DECODE: ir_q is decoded into registered control fields; -> EXECUTE.
//  EXECUTE: strobes are high for exactly this cycle; all are registered, glitch-free.
//    The consuming register captures on the edge leaving EXECUTE.
//    That edge also advances pc and selects the next state:
//    run=1 -> FETCH; run=0 -> IDLE. The current instruction always completes.
//  Latency: instr valid in FETCH -> strobes 2 edges later; 3 pulses per instruction.
//  Decode (op=ir_q[7:4], d=ir_q[3:2] dst/src: 00 A, 01 B, 10 OUT, 11 none):
//    0000-0111  alu_en=1, alu_sel=op; w_sel=0
//    1000       w_sel=1 (ALU); load strobe per d
//    1001       w_sel=2 (SW A); load strobe per d
//    1010       w_sel=3 (SW B); load strobe per d
//    1011       w_sel=4 if d==00 else 5; ld_out=1
//    1111       HALT: no strobes; pc not advanced; -> HALT
//    other      NOP: no strobes; pc advances
//  d=11 with 1000-1010: executes as NOP, but w_sel is still driven.
//  At most one of ld_a/ld_b/ld_out is high in any cycle.
//  pc=PROG_LEN-1 at end of EXECUTE:
//    WRAP=1 -> pc<=0, continue.
//    WRAP=0 -> HALT, pc held.
//  HALT: all strobes 0, halted=1; exits only on reset.
//  Outside EXECUTE: alu_sel holds its last value; w_sel=0.
// TESTING
//  1. reset; run=1; ROM[0]=8'h90.
//     -> ld_ir in pulse 1, ld_a=1 and w_sel=2 in pulse 3 only; pc=1 after pulse 3.
//  2. ROM[0..3]=90,A4,20,80; SW A=5, SW B=7.
//     -> alu_en with alu_sel=2 at pulse 9; ld_a with w_sel=1 at pulse 12; A=35.
//  3. run dropped in DECODE.
//     -> EXECUTE still strobes; state IDLE next; pc advanced once; resume from that pc.
//  4. ROM[2]=F0 -> HALT after pulse 9, pc=2, halted=1.
//     Further pulses produce no strobes; reset -> IDLE, pc=0.
//  5. PROG_LEN=4, all NOP. WRAP=1 -> pc 3->0. WRAP=0 -> HALT with pc=3.
//  6. reset asserted in EXECUTE -> that edge produces no load; all outputs reset values.

Source files
------------

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/execute control FSM for the 8-bit processor
//
// Steps one ROM instruction per three one_shot_clock pulses (FETCH, DECODE,
// EXECUTE) and drives registered, glitch-free one-cycle strobes for the
// A/B/OUT registers, the ALU and the w_bus source mux.
//
// Ports:
//   one_shot_clock  step clock (one edge per debounced key press)
//   reset           synchronous, active-high; overrides run and any instruction
//   run             enable stepping out of IDLE / continue after EXECUTE
//   instr           ROM word at address pc (combinational ROM)
//   pc              program counter to the ROM
//   ld_ir           instruction-register load strobe, high in FETCH
//   ld_a/ld_b/ld_out register loads from w_bus, high only in EXECUTE
//   alu_en          ALU latch strobe, high only in EXECUTE
//   alu_sel         ALU operation select, holds outside EXECUTE
//   w_sel           w_bus source: 0 none, 1 ALU, 2 SW[7:0], 3 SW[15:8], 4 A, 5 B
//   state           FSM state code: IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, HALT 4
//   halted          high in HALT
module instr_sequencer #(
   parameter int PC_W     = 8,
   parameter int PROG_LEN = 16,
   parameter bit WRAP     = 1'b0
) (
   input  logic            one_shot_clock,
   input  logic            reset,
   input  logic            run,
   input  logic [7:0]      instr,
   output logic [PC_W-1:0] pc,
   output logic            ld_ir,
   output logic            ld_a,
   output logic            ld_b,
   output logic            ld_out,
   output logic            alu_en,
   output logic [3:0]      alu_sel,
   output logic [2:0]      w_sel,
   output logic [2:0]      state,
   output logic            halted
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXECUTE = 3'd3,
      S_HALT    = 3'd4
   } state_t;

   localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

   state_t          state_q, state_d;
   logic [7:0]      ir_q, ir_d;
   logic [PC_W-1:0] pc_d;
   logic            ld_ir_d, ld_a_d, ld_b_d, ld_out_d, alu_en_d;
   logic [3:0]      alu_sel_d;
   logic [2:0]      w_sel_d;
   logic            dst_load;

   logic [3:0] op;
   logic [1:0] dst;
   logic       unused_ir_bits;

   assign op             = ir_q[7:4];
   assign dst            = ir_q[3:2];
   assign unused_ir_bits = ^ir_q[1:0];

   assign state  = state_q;
   assign halted = (state_q == S_HALT);

   always_ff @(posedge one_shot_clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc      <= '0;
         ir_q    <= '0;
         ld_ir   <= 1'b0;
         ld_a    <= 1'b0;
         ld_b    <= 1'b0;
         ld_out  <= 1'b0;
         alu_en  <= 1'b0;
         alu_sel <= 4'd0;
         w_sel   <= 3'd0;
      end else begin
         state_q <= state_d;
         pc      <= pc_d;
         ir_q    <= ir_d;
         ld_ir   <= ld_ir_d;
         ld_a    <= ld_a_d;
         ld_b    <= ld_b_d;
         ld_out  <= ld_out_d;
         alu_en  <= alu_en_d;
         alu_sel <= alu_sel_d;
         w_sel   <= w_sel_d;
      end
   end

   // Strobe values are computed one state ahead and registered on the edge
   // that enters the state they belong to, so every output comes straight
   // from a flop. Everything defaults to 0 so leaving EXECUTE clears them.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc;
      ir_d      = ir_q;
      ld_a_d    = 1'b0;
      ld_b_d    = 1'b0;
      ld_out_d  = 1'b0;
      alu_en_d  = 1'b0;
      alu_sel_d = alu_sel;
      w_sel_d   = 3'd0;
      dst_load  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_d    = instr;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            state_d = S_EXECUTE;
            if (!op[3]) begin
               alu_en_d  = 1'b1;
               alu_sel_d = op;
            end else begin
               case (op)
                  4'h8: begin w_sel_d = 3'd1; dst_load = 1'b1; end
                  4'h9: begin w_sel_d = 3'd2; dst_load = 1'b1; end
                  4'hA: begin w_sel_d = 3'd3; dst_load = 1'b1; end
                  4'hB: begin
                     w_sel_d  = (dst == 2'b00) ? 3'd4 : 3'd5;
                     ld_out_d = 1'b1;
                  end
                  default: ;
               endcase
            end
            // dst 11 leaves the mux driven but loads nothing
            if (dst_load) begin
               case (dst)
                  2'b00:   ld_a_d   = 1'b1;
                  2'b01:   ld_b_d   = 1'b1;
                  2'b10:   ld_out_d = 1'b1;
                  default: ;
               endcase
            end
         end
         S_EXECUTE: begin
            if (op == 4'hF) begin
               state_d = S_HALT;
            end else if (pc == LAST_PC) begin
               if (WRAP) begin
                  pc_d    = '0;
                  state_d = run ? S_FETCH : S_IDLE;
               end else begin
                  state_d = S_HALT;
               end
            end else begin
               pc_d    = pc + PC_W'(1);
               state_d = run ? S_FETCH : S_IDLE;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ld_ir_d = (state_d == S_FETCH);
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with instruction-level reference model
module tb_instr_sequencer;

   typedef struct packed {
      logic [7:0] pc;
      logic       ld_a;
      logic       ld_b;
      logic       ld_out;
      logic       alu_en;
      logic [3:0] alu_sel;
      logic [2:0] w_sel;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0;
   logic [7:0] instr;
   logic [7:0] pc;
   logic       ld_ir, ld_a, ld_b, ld_out, alu_en, halted;
   logic [3:0] alu_sel;
   logic [2:0] w_sel, state;

   logic [7:0] pc_w;
   logic       ld_ir_w, ld_a_w, ld_b_w, ld_out_w, alu_en_w, halted_w;
   logic [3:0] alu_sel_w;
   logic [2:0] w_sel_w, state_w;

   logic [7:0] rom [16];
   exp_t       sb [$];
   logic       mon_en = 1'b0;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   assign instr = rom[pc[3:0]];

   instr_sequencer u_dut (
      .one_shot_clock(clk), .reset(reset), .run(run), .instr(instr), .pc(pc),
      .ld_ir(ld_ir), .ld_a(ld_a), .ld_b(ld_b), .ld_out(ld_out), .alu_en(alu_en),
      .alu_sel(alu_sel), .w_sel(w_sel), .state(state), .halted(halted)
   );

   instr_sequencer #(.PC_W(8), .PROG_LEN(4), .WRAP(1'b1)) u_wrap (
      .one_shot_clock(clk), .reset(reset), .run(run), .instr(8'hC0), .pc(pc_w),
      .ld_ir(ld_ir_w), .ld_a(ld_a_w), .ld_b(ld_b_w), .ld_out(ld_out_w), .alu_en(alu_en_w),
      .alu_sel(alu_sel_w), .w_sel(w_sel_w), .state(state_w), .halted(halted_w)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] mk(input logic ir, a, b, o, alu, input logic [3:0] sel,
                                      input logic [2:0] w, st, input logic h);
      return {ir, a, b, o, alu, sel, w, st, h};
   endfunction

   function automatic logic [15:0] obs();
      return {ld_ir, ld_a, ld_b, ld_out, alu_en, alu_sel, w_sel, state, halted};
   endfunction

   task automatic chkv(input string name, input logic [15:0] exp_v, input logic [7:0] exp_pc);
      chk({name, "_outputs"}, obs(), exp_v);
      chk({name, "_pc"}, pc, exp_pc);
   endtask

   task automatic pulse();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      reset  = 1'b1;
      pulse();
      reset  = 1'b0;
   endtask

   // Walks the program one instruction at a time from pc 0 and queues what
   // each EXECUTE must show. The sequence does not depend on run timing.
   task automatic build_model(output logic [7:0] halt_pc);
      int         p = 0;
      logic [3:0] alu_m = 4'd0;
      logic [3:0] op;
      logic [1:0] d;
      exp_t       e;
      halt_pc = 8'd0;
      for (int n = 0; n < 16; n++) begin
         op = rom[p][7:4];
         d  = rom[p][3:2];
         e  = '0;
         e.pc = 8'(p);
         if (op < 4'd8) begin
            e.alu_en = 1'b1;
            alu_m    = op;
         end else if (op <= 4'd10) begin
            e.w_sel = 3'(op - 4'd7);
            if (d == 2'd0) e.ld_a = 1'b1;
            if (d == 2'd1) e.ld_b = 1'b1;
            if (d == 2'd2) e.ld_out = 1'b1;
         end else if (op == 4'd11) begin
            e.w_sel  = (d == 2'd0) ? 3'd4 : 3'd5;
            e.ld_out = 1'b1;
         end
         e.alu_sel = alu_m;
         sb.push_back(e);
         if (op == 4'hF || p == 15) begin
            halt_pc = 8'(p);
            break;
         end
         p++;
      end
   endtask

   exp_t act_m, exp_m;
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         if (state == 3'd3) begin
            act_m = {pc, ld_a, ld_b, ld_out, alu_en, alu_sel, w_sel};
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: execute at pc %0d, expected no further instruction", pc);
            end else begin
               exp_m = sb.pop_front();
               chk("sb_execute", act_m, exp_m);
            end
         end else begin
            chk("quiet_outside_execute", {ld_a, ld_b, ld_out, alu_en, w_sel}, 32'd0);
         end
         chk("one_load_max", ($countones({ld_a, ld_b, ld_out}) <= 1), 32'd1);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] hpc;
      logic [7:0] w;

      // Straight-line program with latency checks on every interesting pulse
      for (int i = 0; i < 16; i++) rom[i] = 8'hC0;
      rom[0] = 8'h90; rom[1] = 8'hA4; rom[2] = 8'h20; rom[3] = 8'h80; rom[4] = 8'hF0;
      run = 1'b1;
      do_reset();
      chkv("reset", 16'h0, 8'd0);
      for (int p = 1; p <= 19; p++) begin
         pulse();
         case (p)
            1:  chkv("p1_fetch",  mk(1,0,0,0,0,4'd0,3'd0,3'd1,0), 8'd0);
            2:  chkv("p2_decode", mk(0,0,0,0,0,4'd0,3'd0,3'd2,0), 8'd0);
            3:  chkv("p3_ld_a",   mk(0,1,0,0,0,4'd0,3'd2,3'd3,0), 8'd0);
            4:  chkv("p4_fetch",  mk(1,0,0,0,0,4'd0,3'd0,3'd1,0), 8'd1);
            6:  chkv("p6_ld_b",   mk(0,0,1,0,0,4'd0,3'd3,3'd3,0), 8'd1);
            9:  chkv("p9_alu",    mk(0,0,0,0,1,4'd2,3'd0,3'd3,0), 8'd2);
            12: chkv("p12_ld_a",  mk(0,1,0,0,0,4'd2,3'd1,3'd3,0), 8'd3);
            13: chkv("p13_fetch", mk(1,0,0,0,0,4'd2,3'd0,3'd1,0), 8'd4);
            15: chkv("p15_halt_exec", mk(0,0,0,0,0,4'd2,3'd0,3'd3,0), 8'd4);
            16: chkv("p16_halted", mk(0,0,0,0,0,4'd2,3'd0,3'd4,1), 8'd4);
            19: chkv("p19_halted", mk(0,0,0,0,0,4'd2,3'd0,3'd4,1), 8'd4);
            default: ;
         endcase
      end
      do_reset();
      chkv("halt_reset", 16'h0, 8'd0);

      // run dropped in DECODE: the instruction finishes, then IDLE
      rom[4] = 8'hC0;
      run = 1'b1;
      do_reset();
      pulse(); pulse();
      run = 1'b0;
      pulse();
      chkv("drop_exec", mk(0,1,0,0,0,4'd0,3'd2,3'd3,0), 8'd0);
      pulse();
      chkv("drop_idle", 16'h0, 8'd1);
      pulse();
      chkv("drop_hold", 16'h0, 8'd1);
      run = 1'b1;
      pulse();
      chkv("resume_fetch", mk(1,0,0,0,0,4'd0,3'd0,3'd1,0), 8'd1);
      pulse(); pulse();
      chkv("resume_exec", mk(0,0,1,0,0,4'd0,3'd3,3'd3,0), 8'd1);

      // reset landing on the EXECUTE edge
      rom[0] = 8'h20;
      do_reset();
      pulse(); pulse(); pulse();
      chkv("pre_reset_exec", mk(0,0,0,0,1,4'd2,3'd0,3'd3,0), 8'd0);
      reset = 1'b1;
      pulse();
      reset = 1'b0;
      chkv("reset_in_exec", 16'h0, 8'd0);

      // 4-word wrapping instance, all NOPs
      run = 1'b1;
      do_reset();
      for (int p = 1; p <= 13; p++) begin
         pulse();
         if (p == 10) chk("wrap_pc_last", pc_w, 8'd3);
         if (p == 13) begin
            chk("wrap_pc_zero", pc_w, 8'd0);
            chk("wrap_state", state_w, 32'd1);
            chk("wrap_not_halted", halted_w, 32'd0);
         end
      end

      // Randomized programs with random run gaps
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 16; i++) begin
            w = 8'($urandom_range(0, 255));
            if (t == 0 && w[7:4] == 4'hF) w[7:4] = 4'hE;
            rom[i] = w;
         end
         if (t % 2 == 1) rom[$urandom_range(2, 14)] = 8'hF3;
         do_reset();
         build_model(hpc);
         mon_en = 1'b1;
         for (int c = 0; c < 400; c++) begin
            run = ($urandom_range(0, 3) != 0);
            pulse();
            if (sb.size() == 0 && halted) break;
         end
         chk("rand_sb_drained", sb.size(), 32'd0);
         chk("rand_halted", halted, 32'd1);
         chk("rand_halt_pc", pc, hpc);
         mon_en = 1'b0;
         sb.delete();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
